// File: rtl/adder_final.sv
// Sums 1+2+...+N (N from count) one term per FREQ-cycle tick, shows last result on 3 7-seg digits.
// Latency: result updates 2+(N+1)*FREQ edges after enable is first seen high in IDLE.
// No backpressure: enable is a level request; dropping it during ADD aborts, during DONE re-arms.
module adder_final #(
   parameter int FREQ = 50_000_000
) (
   input  logic       clk,
   input  logic       rst_a_p,
   input  logic       enable,
   input  logic [3:0] count,
   output logic [0:6] unidades,
   output logic [0:6] decenas,
   output logic [0:6] centenas
);

   localparam int DW = (FREQ > 1) ? $clog2(FREQ) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(FREQ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ADD  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t          current_state;
   state_t          next_state;
   logic [3:0]      limit;
   logic [4:0]      counter;
   logic [6:0]      sum;
   logic [6:0]      result;
   logic [DW-1:0]   divider;
   logic            tick;
   logic            in_range;

   assign tick     = (divider == DIV_LAST);
   assign in_range = (counter <= {1'b0, limit});

   // Step divider: free-running modulo FREQ, restarted in LOAD so each step is exactly FREQ cycles.
   always_ff @(posedge clk or negedge rst_a_p) begin
      if (!rst_a_p) begin
         divider <= '0;
      end else if (current_state == LOAD || tick) begin
         divider <= '0;
      end else begin
         divider <= divider + DW'(1);
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst_a_p) begin
      if (!rst_a_p) begin
         current_state <= IDLE;
      end else begin
         current_state <= next_state;
      end
   end

   // Next-state logic; an enable drop in ADD wins over a completing tick.
   always_comb begin
      next_state = current_state;
      case (current_state)
         IDLE: if (enable) next_state = LOAD;
         LOAD: next_state = ADD;
         ADD: begin
            if (!enable) begin
               next_state = IDLE;
            end else if (tick && !in_range) begin
               next_state = DONE;
            end
         end
         DONE: if (!enable) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Series datapath: load operands, accumulate one term per tick, latch the finished sum.
   always_ff @(posedge clk or negedge rst_a_p) begin
      if (!rst_a_p) begin
         limit   <= '0;
         counter <= '0;
         sum     <= '0;
         result  <= '0;
      end else begin
         if (current_state == LOAD) begin
            limit   <= count;
            counter <= 5'd1;
            sum     <= '0;
         end else if (current_state == ADD && enable && tick) begin
            if (in_range) begin
               sum     <= sum + {2'b00, counter};
               counter <= counter + 5'd1;
            end else begin
               result  <= sum;
            end
         end
      end
   end

   // Segment patterns abcdefg (a leftmost), active low; anything outside 0..9 blanks.
   function automatic logic [0:6] seg7(input logic [6:0] d);
      case (d)
         7'd0:    seg7 = 7'b0000001;
         7'd1:    seg7 = 7'b1001111;
         7'd2:    seg7 = 7'b0010010;
         7'd3:    seg7 = 7'b0000110;
         7'd4:    seg7 = 7'b1001100;
         7'd5:    seg7 = 7'b0100100;
         7'd6:    seg7 = 7'b0100000;
         7'd7:    seg7 = 7'b0001111;
         7'd8:    seg7 = 7'b0000000;
         7'd9:    seg7 = 7'b0000100;
         default: seg7 = 7'b1111111;
      endcase
   endfunction

   logic [6:0] dig_h;
   logic [6:0] dig_t;
   logic [6:0] dig_u;

   // Binary to decimal digits by constant div/mod; result is at most 120.
   always_comb begin
      dig_h = result / 7'd100;
      dig_t = (result / 7'd10) % 7'd10;
      dig_u = result % 7'd10;
   end

   assign centenas = seg7(dig_h);
   assign decenas  = seg7(dig_t);
   assign unidades = seg7(dig_u);

endmodule

// File: tb/tb_adder_final.sv
// Bench for adder_final: FREQ=1 and FREQ=4 instances against a closed-form run model.
// Directed runs pin exact latencies and segment codes; random enable/count traffic follows.
// Every negedge after reset release compares all six digit outputs to the model.
module tb_adder_final;

   logic       clk;
   logic       rst_a_p;
   logic       e1, e4;
   logic [3:0] c1, c4;
   logic [0:6] u1, d1, h1;
   logic [0:6] u4, d4, h4;

   int n_checks;
   int n_pass;
   bit chk_en;

   adder_final #(.FREQ(1)) dut (
      .clk(clk), .rst_a_p(rst_a_p), .enable(e1), .count(c1),
      .unidades(u1), .decenas(d1), .centenas(h1)
   );

   adder_final #(.FREQ(4)) dut4 (
      .clk(clk), .rst_a_p(rst_a_p), .enable(e4), .count(c4),
      .unidades(u4), .decenas(d4), .centenas(h4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] seg_tab [10];
   initial begin
      seg_tab[0] = 7'b0000001; seg_tab[1] = 7'b1001111; seg_tab[2] = 7'b0010010;
      seg_tab[3] = 7'b0000110; seg_tab[4] = 7'b1001100; seg_tab[5] = 7'b0100100;
      seg_tab[6] = 7'b0100000; seg_tab[7] = 7'b0001111; seg_tab[8] = 7'b0000000;
      seg_tab[9] = 7'b0000100;
   end

   // Run model: phase 0 idle, 1 running (k = edges since start), 2 done; result in closed form.
   int ph  [2];
   int k   [2];
   int n   [2];
   int res [2];
   int fq  [2];
   initial begin
      fq[0] = 1;
      fq[1] = 4;
   end

   task automatic step(input int d, input logic en, input logic [3:0] cn);
      case (ph[d])
         0: if (en) begin ph[d] = 1; k[d] = 1; end
         1: begin
            k[d] = k[d] + 1;
            if (k[d] == 2) begin
               n[d] = int'(cn);
            end else if (!en) begin
               ph[d] = 0;
            end else if (k[d] == 2 + (n[d] + 1) * fq[d]) begin
               res[d] = n[d] * (n[d] + 1) / 2;
               ph[d]  = 2;
            end
         end
         default: if (!en) ph[d] = 0;
      endcase
   endtask

   always @(posedge clk or negedge rst_a_p) begin
      if (!rst_a_p) begin
         for (int i = 0; i < 2; i++) begin
            ph[i]  = 0;
            k[i]   = 0;
            res[i] = 0;
         end
      end else begin
         step(0, e1, c1);
         step(1, e4, c4);
      end
   end

   task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
   endtask

   task automatic chk_int(input string nm, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
   endtask

   // Continuous compare of both instances against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("cmp_u1", u1, seg_tab[res[0] % 10]);
         chk("cmp_d1", d1, seg_tab[(res[0] / 10) % 10]);
         chk("cmp_h1", h1, seg_tab[res[0] / 100]);
         chk("cmp_u4", u4, seg_tab[res[1] % 10]);
         chk("cmp_d4", d4, seg_tab[(res[1] / 10) % 10]);
         chk("cmp_h4", h4, seg_tab[res[1] / 100]);
      end
   end

   task automatic cyc(input int nc);
      repeat (nc) @(posedge clk);
      #1;
   endtask

   task automatic chk_all1(input string nm, input logic [6:0] eh, input logic [6:0] ed, input logic [6:0] eu);
      chk({nm, "_h"}, h1, eh);
      chk({nm, "_d"}, d1, ed);
      chk({nm, "_u"}, u1, eu);
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      chk_en   = 1'b0;
      rst_a_p  = 1'b0;
      e1 = 1'b0; e4 = 1'b0; c1 = 4'd0; c4 = 4'd0;

      #21;
      chk_all1("rst0", 7'b0000001, 7'b0000001, 7'b0000001);
      chk("rst0_u4", u4, 7'b0000001);
      #1 rst_a_p = 1'b1;
      chk_en = 1'b1;

      // FREQ=1, N=5: result lands exactly at edge 8.
      cyc(1);
      c1 = 4'd5; e1 = 1'b1;
      cyc(7);
      chk("n5_edge7_u", u1, 7'b0000001);
      cyc(1);
      chk_all1("n5", 7'b0000001, 7'b1001111, 7'b0100100);
      chk_int("model_n5", res[0], 15);
      c1 = 4'd9;
      cyc(2);

      // Re-arm and N=3 -> 6.
      e1 = 1'b0; cyc(2);
      c1 = 4'd3; e1 = 1'b1; cyc(8);
      chk_all1("n3", 7'b0000001, 7'b0000001, 7'b0100000);

      // N=15 -> 120.
      e1 = 1'b0; cyc(2);
      c1 = 4'd15; e1 = 1'b1; cyc(2);
      c1 = 4'd1;
      cyc(18);
      chk_all1("n15", 7'b1001111, 7'b0010010, 7'b0000001);
      chk_int("model_n15", res[0], 120);

      // N=0 -> 0 after 3 edges.
      e1 = 1'b0; cyc(2);
      c1 = 4'd0; e1 = 1'b1; cyc(3);
      chk_all1("n0", 7'b0000001, 7'b0000001, 7'b0000001);

      // N=9 aborted mid-ADD: display keeps 0.
      e1 = 1'b0; cyc(2);
      c1 = 4'd9; e1 = 1'b1; cyc(6);
      e1 = 1'b0; cyc(12);
      chk_all1("abort", 7'b0000001, 7'b0000001, 7'b0000001);

      // FREQ=4, N=2: result 3 at edge 14, then no restart while enable stays high.
      c4 = 4'd2; e4 = 1'b1;
      cyc(13);
      chk("f4_edge13_u", u4, 7'b0000001);
      cyc(1);
      chk("f4_edge14_u", u4, 7'b0000110);
      chk("f4_edge14_d", d4, 7'b0000001);
      chk_int("model_f4", res[1], 3);
      c4 = 4'd5;
      cyc(40);
      chk("f4_hold_u", u4, 7'b0000110);
      e4 = 1'b0; cyc(2);

      // Random traffic with one asynchronous mid-run reset.
      for (int it = 0; it < 4000; it++) begin
         @(posedge clk);
         #1;
         if ($urandom_range(0, 15) == 0) e1 = ~e1;
         if ($urandom_range(0, 39) == 0) e4 = ~e4;
         c1 = 4'($urandom_range(0, 15));
         c4 = 4'($urandom_range(0, 15));
         if (it == 2000) begin
            #1 rst_a_p = 1'b0;
            #1;
            chk_all1("mid_rst", 7'b0000001, 7'b0000001, 7'b0000001);
            chk("mid_rst_u4", u4, 7'b0000001);
            #8 rst_a_p = 1'b1;
         end
      end

      cyc(2);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
